// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: generic pipeline-stage register with a valid/ready handshake
// and a 2-entry skid buffer. The main entry M drives the outputs and the skid
// entry S is internal. O_IN_READY is a register, so there is no combinational
// path from I_OUT_READY back to the upstream stage.
//
// Optional feature: define PIPE_SKID_REG_PERF_CNT_EN to enable the saturating
// stall and bubble counters. When it is undefined, both counter ports are 0.
//
// Ports:
//   CLK           clock, all state updates on the rising edge
//   RESET         synchronous active-low reset
//   I_VALID       upstream item valid
//   I_DATA        upstream payload, DATA_W bits
//   I_PC          upstream PC, PC_W bits
//   O_IN_READY    registered; high when an item can be accepted this cycle
//   O_VALID       main entry holds a valid item
//   O_DATA        main-entry payload (NOP_VALUE while empty after a drain or flush)
//   O_PC          main-entry PC (0 while empty)
//   I_OUT_READY   downstream accepts the item
//   I_FLUSH       discard all contents and emit a bubble
//   O_STALL_CNT   cycles with O_VALID=1 and I_OUT_READY=0 (optional)
//   O_BUBBLE_CNT  cycles with O_VALID=0 and I_OUT_READY=1 (optional)
module pipe_skid_reg #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PC_W      = 32,
  parameter logic [31:0] NOP_VALUE = 32'hF800_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_VALID,
  input  logic [DATA_W-1:0] I_DATA,
  input  logic [PC_W-1:0]   I_PC,
  output logic              O_IN_READY,
  output logic              O_VALID,
  output logic [DATA_W-1:0] O_DATA,
  output logic [PC_W-1:0]   O_PC,
  input  logic              I_OUT_READY,
  input  logic              I_FLUSH,
  output logic [CNT_W-1:0]  O_STALL_CNT,
  output logic [CNT_W-1:0]  O_BUBBLE_CNT
);

  // NOP_VALUE is truncated or zero-extended to the payload width.
  localparam logic [DATA_W-1:0] NOP_D = DATA_W'(NOP_VALUE);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e              state_q;
  logic                valid_q;
  logic                in_ready_q;
  logic [DATA_W-1:0]   m_data_q;
  logic [PC_W-1:0]     m_pc_q;
  logic [DATA_W-1:0]   s_data_q;
  logic [PC_W-1:0]     s_pc_q;

  logic                in_xfer;
  logic                out_xfer;

  assign in_xfer  = I_VALID & in_ready_q;
  assign out_xfer = valid_q & I_OUT_READY;

  assign O_IN_READY = in_ready_q;
  assign O_VALID    = valid_q;
  assign O_DATA     = m_data_q;
  assign O_PC       = m_pc_q;

  // Storage and handshake state machine. Reset has priority over flush, and
  // flush has priority over both handshakes.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= ST_EMPTY;
      valid_q    <= 1'b0;
      in_ready_q <= 1'b1;
      m_data_q   <= '0;
      m_pc_q     <= '0;
      s_data_q   <= '0;
      s_pc_q     <= '0;
    end else if (I_FLUSH) begin
      // A same-cycle out_xfer has already completed, because downstream sampled
      // the current outputs. Any same-cycle input is dropped.
      state_q    <= ST_EMPTY;
      valid_q    <= 1'b0;
      in_ready_q <= 1'b1;
      m_data_q   <= NOP_D;
      m_pc_q     <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            m_data_q <= I_DATA;
            m_pc_q   <= I_PC;
            valid_q  <= 1'b1;
            state_q  <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            m_data_q <= I_DATA;
            m_pc_q   <= I_PC;
          end else if (in_xfer) begin
            // Downstream is stalled, so the new item parks in the skid entry.
            s_data_q   <= I_DATA;
            s_pc_q     <= I_PC;
            in_ready_q <= 1'b0;
            state_q    <= ST_TWO;
          end else if (out_xfer) begin
            valid_q  <= 1'b0;
            m_data_q <= NOP_D;
            m_pc_q   <= '0;
            state_q  <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // Input is blocked here, so the skid entry always drains before any newer item.
          if (out_xfer) begin
            m_data_q   <= s_data_q;
            m_pc_q     <= s_pc_q;
            in_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q    <= ST_EMPTY;
          valid_q    <= 1'b0;
          in_ready_q <= 1'b1;
          m_data_q   <= NOP_D;
          m_pc_q     <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_REG_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_d;

  // Saturating increments. Flush does not clear the counters.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (valid_q && !I_OUT_READY && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (!valid_q && I_OUT_READY && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign O_STALL_CNT  = stall_cnt_q;
  assign O_BUBBLE_CNT = bubble_cnt_q;
`else
  assign O_STALL_CNT  = '0;
  assign O_BUBBLE_CNT = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_pipe_skid_reg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP     = 32'hF800_0000;

  logic              clk;
  logic              rst_n;
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic [PC_W-1:0]   i_pc;
  logic              o_in_ready;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic [PC_W-1:0]   o_pc;
  logic              i_out_ready;
  logic              i_flush;
  logic [CNT_W-1:0]  o_stall_cnt;
  logic [CNT_W-1:0]  o_bubble_cnt;

  pipe_skid_reg #(
    .DATA_W   (DATA_W),
    .PC_W     (PC_W),
    .NOP_VALUE(NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .CLK         (clk),
    .RESET       (rst_n),
    .I_VALID     (i_valid),
    .I_DATA      (i_data),
    .I_PC        (i_pc),
    .O_IN_READY  (o_in_ready),
    .O_VALID     (o_valid),
    .O_DATA      (o_data),
    .O_PC        (o_pc),
    .I_OUT_READY (i_out_ready),
    .I_FLUSH     (i_flush),
    .O_STALL_CNT (o_stall_cnt),
    .O_BUBBLE_CNT(o_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the stage is a FIFO of depth 2, and it can accept an
  // item whenever it holds fewer than two.
  typedef struct packed {
    logic [31:0] d;
    logic [31:0] pc;
  } item_t;

  item_t       mq[$];
  logic [31:0] m_empty_d = 32'h0;
  int          m_stall   = 0;
  int          m_bubble  = 0;

  task automatic model_update(input logic rst, input logic v, input logic [31:0] d,
                              input logic [31:0] pc, input logic ordy, input logic fl);
    bit was_valid;
    bit acc;
    bit out;
    was_valid = (mq.size() > 0);
    acc       = v && (mq.size() < 2);
    out       = was_valid && ordy;
    if (!rst) begin
      mq.delete();
      m_empty_d = 32'h0;
      m_stall   = 0;
      m_bubble  = 0;
    end else begin
      if (was_valid && !ordy && m_stall < CNT_MAX) m_stall++;
      if (!was_valid && ordy && m_bubble < CNT_MAX) m_bubble++;
      if (fl) begin
        mq.delete();
        m_empty_d = NOP;
      end else begin
        if (out) void'(mq.pop_front());
        if (acc) mq.push_back(item_t'{d: d, pc: pc});
        if (out && mq.size() == 0) m_empty_d = NOP;
      end
    end
  endtask

  task automatic compare_all();
    bit          ev;
    logic [31:0] ed;
    logic [31:0] ep;
    ev = (mq.size() > 0);
    ed = ev ? mq[0].d  : m_empty_d;
    ep = ev ? mq[0].pc : 32'h0;
    check_eq("o_valid",    64'(o_valid),    64'(ev));
    check_eq("o_data",     64'(o_data),     64'(ed));
    check_eq("o_pc",       64'(o_pc),       64'(ep));
    check_eq("o_in_ready", 64'(o_in_ready), 64'(mq.size() < 2));
`ifdef PIPE_SKID_REG_PERF_CNT_EN
    check_eq("stall_cnt",  64'(o_stall_cnt),  64'(m_stall));
    check_eq("bubble_cnt", 64'(o_bubble_cnt), 64'(m_bubble));
`else
    check_eq("stall_cnt",  64'(o_stall_cnt),  64'(0));
    check_eq("bubble_cnt", 64'(o_bubble_cnt), 64'(0));
`endif
  endtask

  // One clock cycle: drive on the falling edge, update the model on the rising
  // edge, and compare 1 time unit later.
  task automatic step(input logic rst, input logic v, input logic [31:0] d,
                      input logic [31:0] pc, input logic ordy, input logic fl);
    @(negedge clk);
    rst_n       = rst;
    i_valid     = v;
    i_data      = d;
    i_pc        = pc;
    i_out_ready = ordy;
    i_flush     = fl;
    @(posedge clk);
    model_update(rst, v, d, pc, ordy, fl);
    #1;
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_pc = '0;
    i_out_ready = 1'b0; i_flush = 1'b0;

    // Reset, then stream eight items.
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    check_eq("rst_data", 64'(o_data), 64'(0));
    check_eq("rst_ready", 64'(o_in_ready), 64'(1));
    for (int n = 0; n < 8; n++) begin
      step(1, 1, 32'h1000 + 32'(n), 32'(4 * n), 1, 0);
      check_eq("stream_data", 64'(o_data), 64'(32'h1000 + 32'(n)));
    end
    step(1, 0, 0, 0, 1, 0);
    check_eq("stream_drain", 64'(o_data), 64'(NOP));

    // Stall into the skid entry, then release.
    step(1, 1, 32'hA, 32'h40, 0, 0);
    step(1, 1, 32'hB, 32'h44, 0, 0);
    check_eq("skid_ready", 64'(o_in_ready), 64'(0));
    check_eq("skid_hold", 64'(o_data), 64'(32'hA));
    step(1, 0, 0, 0, 1, 0);
    check_eq("skid_second", 64'(o_data), 64'(32'hB));
    check_eq("skid_ready_back", 64'(o_in_ready), 64'(1));
    step(1, 0, 0, 0, 1, 0);

    // Flush while two items are held, with an input in the same cycle.
    step(1, 1, 32'hA, 32'h50, 0, 0);
    step(1, 1, 32'hB, 32'h54, 0, 0);
    step(1, 1, 32'hC, 32'h58, 0, 1);
    check_eq("flush_valid", 64'(o_valid), 64'(0));
    check_eq("flush_data", 64'(o_data), 64'(NOP));
    check_eq("flush_ready", 64'(o_in_ready), 64'(1));
    step(1, 0, 0, 0, 1, 0);
    check_eq("flush_after", 64'(o_valid), 64'(0));

    // Reset takes priority over flush.
    step(1, 1, 32'hD, 32'h60, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    check_eq("rstprio_data", 64'(o_data), 64'(0));
    check_eq("rstprio_valid", 64'(o_valid), 64'(0));

    // Drain a single item.
    step(1, 1, 32'h55, 32'h70, 1, 0);
    check_eq("drain_item", 64'(o_data), 64'(32'h55));
    step(1, 0, 0, 0, 1, 0);
    check_eq("drain_nop", 64'(o_data), 64'(NOP));
    check_eq("drain_pc", 64'(o_pc), 64'(0));

    // Stall counter saturation: flush keeps the count and reset clears it.
    step(1, 1, 32'h77, 32'h80, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0);
`ifdef PIPE_SKID_REG_PERF_CNT_EN
    check_eq("stall_sat", 64'(o_stall_cnt), 64'(15));
`endif
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    check_eq("stall_rst", 64'(o_stall_cnt), 64'(0));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(63) != 0), ($urandom_range(1) == 1), $urandom, $urandom,
           ($urandom_range(2) != 0), ($urandom_range(15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised successor to the fixed IF/ID stage register: a generic pipeline-stage register with valid/ready handshake and a 2-entry skid buffer.
- Lets a stage stall without a combinational ready path back to the upstream stage.
- Carries an instruction-sized payload plus a PC. Supports flush with NOP bubble injection.
- Placed between any two MIPS pipeline stages (IF/ID first, then ID/EX and beyond).

Parameters:
- DATA_W, 32, payload (instruction/control word) width in bits.
- PC_W, 32, PC field width in bits.
- NOP_VALUE, 32'hF800_0000 (truncated/zero-extended to DATA_W), payload driven during flush/bubble.
- CNT_W, 16, width of performance counters (used only with the optional feature).

Ports:
- CLK  in  1  single clock, all state updates on rising edge.
- RESET  in  1  synchronous, active-low reset; sampled on the rising edge of CLK, no asynchronous path.
- I_VALID  in  1  upstream presents a valid item.
- I_DATA  in  DATA_W  upstream payload.
- I_PC  in  PC_W  upstream PC.
- O_IN_READY  out  1  registered; block can accept an item this cycle.
- O_VALID  out  1  main entry holds a valid item.
- O_DATA  out  DATA_W  main-entry payload.
- O_PC  out  PC_W  main-entry PC.
- I_OUT_READY  in  1  downstream accepts (low = stall/hazard).
- I_FLUSH  in  1  discard all contents, emit a bubble.
- O_STALL_CNT  out  CNT_W  stall-cycle counter (optional feature).
- O_BUBBLE_CNT  out  CNT_W  bubble-cycle counter (optional feature).

Behaviour:
- Storage:
  - Main entry M (drives O_*).
  - Skid entry S (internal).
  - State: EMPTY (M invalid), ONE (M valid, S invalid), TWO (M and S valid).
- Transfer events:
  - in_xfer = I_VALID & O_IN_READY.
  - out_xfer = O_VALID & I_OUT_READY.
- O_IN_READY is a register equal to "S invalid next cycle", i.e. low only in TWO. It never depends combinationally on I_OUT_READY.
- Latency: 1 cycle I_* -> O_*. Throughput: 1 item/cycle while I_OUT_READY=1.
- Transitions (when RESET high and I_FLUSH low):
  - EMPTY, in_xfer: M<=in, -> ONE. Otherwise hold.
  - ONE, in & out: M<=in, stay ONE.
  - ONE, in & !out: S<=in, -> TWO. M unchanged.
  - ONE, !in & out: -> EMPTY, O_DATA<=NOP_VALUE, O_PC<=0.
  - ONE, !in & !out: hold.
  - TWO, out: M<=S, -> ONE. No input accepted because O_IN_READY=0.
  - TWO, !out: hold all. Upstream must keep I_* stable (standard valid/ready).
- Order is preserved: S always drains to M before any newer item.
- Flush (I_FLUSH=1, RESET high), priority over all handshakes:
  - -> EMPTY, S invalidated, O_DATA<=NOP_VALUE, O_PC<=0, O_IN_READY<=1.
  - Any in_xfer in the same cycle is dropped.
  - out_xfer in the same cycle still completes, since downstream sampled current O_*.
- Reset (RESET=0 at edge), priority over flush:
  - EMPTY, O_VALID=0, O_DATA=0, O_PC=0, O_IN_READY=1, S cleared, counters 0.
  - Reset asserted mid-transfer discards all content.
  - The first item is accepted on the first edge with RESET=1.
- While EMPTY, O_DATA/O_PC always show NOP_VALUE/0, or 0/0 straight after reset. Never stale data.

Optional Feature:
- Macro: PIPE_SKID_REG_PERF_CNT_EN.
- Defined:
  - O_STALL_CNT increments each cycle with O_VALID=1 & I_OUT_READY=0.
  - O_BUBBLE_CNT increments each cycle with O_VALID=0 & I_OUT_READY=1.
  - Both saturate at 2^CNT_W-1, clear only on reset (not on flush), and are registered.
- Not defined: counter logic is absent; both ports are tied to 0.

Test Plan:
- Reset then stream: RESET=0 for 2 cycles, then I_VALID=1 with I_DATA=0x1000+n, I_PC=4n for n=0..7, I_OUT_READY=1 -> O_VALID rises 1 cycle after the first item, O_DATA sequence 0x1000..0x1007, O_PC 0..28, O_IN_READY stays 1.
- Stall into skid: in ONE holding 0xA, I_OUT_READY=0, push 0xB -> state TWO, O_IN_READY=0 next cycle, O_DATA=0xA held. Then release I_OUT_READY -> outputs 0xA, 0xB in order; O_IN_READY=1 the cycle after 0xA leaves.
- Flush in TWO: M=0xA, S=0xB, I_FLUSH=1, I_VALID=1 with 0xC -> next cycle O_VALID=0, O_DATA=0xF8000000, O_PC=0, O_IN_READY=1; 0xB and 0xC never appear.
- Reset priority: RESET=0 and I_FLUSH=1 in the same cycle while in ONE -> O_DATA=0 (not NOP), O_PC=0, O_VALID=0.
- Drain: single item 0x55 with I_OUT_READY=1, then I_VALID=0 -> O_VALID high 1 cycle, then O_DATA=0xF8000000, O_PC=0.
- PERF_CNT_EN with CNT_W=4: hold O_VALID=1 and I_OUT_READY=0 for 20 cycles -> O_STALL_CNT reaches 15 and stays 15; flush leaves it 15; reset clears it to 0.
